// File: rtl/proj_pkg.sv
// proj_pkg: shared widths, buffer size and tracker state type
package proj_pkg;
    localparam int INDICE_LEN     = 3;
    localparam int HASH_LEN       = 16;
    localparam int FM_BUFFER_SIZE = 8;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
endpackage

// File: rtl/proj_min_tracker_if.sv
// proj_min_tracker_if: sample stream in, min-hash result out
interface proj_min_tracker_if #(
    parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
    parameter int HASH_LEN   = proj_pkg::HASH_LEN
);
    logic                  start;
    logic                  in_valid;
    logic [INDICE_LEN-1:0] in_index;
    logic [HASH_LEN-1:0]   in_hash;
    logic                  in_last;
    logic                  res_ready;
    logic                  res_valid;
    logic [HASH_LEN-1:0]   min_hash;
    logic [INDICE_LEN-1:0] min_index;
    logic                  err_len;
    logic                  err_seq;
    logic                  busy;
    modport master (
        output start, in_valid, in_index, in_hash, in_last, res_ready,
        input  res_valid, min_hash, min_index, err_len, err_seq, busy
    );
    modport slave (
        input  start, in_valid, in_index, in_hash, in_last, res_ready,
        output res_valid, min_hash, min_index, err_len, err_seq, busy
    );
endinterface

// File: rtl/proj_min_tracker.sv
// proj_min_tracker: tracks the minimum hash and its first index over one pass
module proj_min_tracker #(
    parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
    parameter int HASH_LEN   = proj_pkg::HASH_LEN,
    parameter int BUF_SIZE   = proj_pkg::FM_BUFFER_SIZE
) (
    input logic               clk,
    input logic               rst,
    proj_min_tracker_if.slave bus
);
    import proj_pkg::*;
    localparam int CW = INDICE_LEN + 1;
    state_t                r_state, w_state_nxt;
    logic [HASH_LEN-1:0]   r_min;
    logic [INDICE_LEN-1:0] r_min_idx;
    logic [CW-1:0]         r_cnt;
    logic                  r_err_len, r_err_seq;
    logic                  w_restart, w_accept, w_take;
    logic [CW-1:0]         w_cnt_inc;
    // start restarts the pass everywhere except HOLD and overrides a same-cycle sample
    assign w_restart = bus.start && r_state != HOLD;
    assign w_accept  = r_state == SCAN && bus.in_valid && !bus.start;
    assign w_take    = r_cnt == '0 || bus.in_hash < r_min;
    assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = bus.start ? SCAN : IDLE;
            SCAN:    w_state_nxt = (w_accept && bus.in_last) ? HOLD : SCAN;
            HOLD:    w_state_nxt = bus.res_ready ? IDLE : HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_min     <= '0;
            r_min_idx <= '0;
            r_cnt     <= '0;
            r_err_len <= 1'b0;
            r_err_seq <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_restart) begin
                r_min     <= '1;
                r_min_idx <= '0;
                r_cnt     <= '0;
                r_err_len <= 1'b0;
                r_err_seq <= 1'b0;
            end else if (w_accept) begin
                if (w_take) begin
                    r_min     <= bus.in_hash;
                    r_min_idx <= bus.in_index;
                end
                r_cnt <= w_cnt_inc;
                if ({1'b0, bus.in_index} != r_cnt) r_err_seq <= 1'b1;
                if (bus.in_last) r_err_len <= (32'(r_cnt) + 32'd1) != 32'(BUF_SIZE);
            end
        end
    end
    assign bus.res_valid = r_state == HOLD;
    assign bus.busy      = r_state != IDLE;
    assign bus.min_hash  = r_min;
    assign bus.min_index = r_min_idx;
    assign bus.err_len   = r_err_len;
    assign bus.err_seq   = r_err_seq;
endmodule

// File: tb/tb_proj_min_tracker.sv
// tb_proj_min_tracker: directed passes with hand-computed minimum, index and error flags
module tb_proj_min_tracker;
    logic clk = 1'b0;
    logic rst;
    int   n_run = 0;
    int   n_fail = 0;

    proj_min_tracker_if bus ();
    proj_min_tracker dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int idx, input int h, input logic last);
        bus.in_valid = 1'b1;
        bus.in_index = 3'(idx);
        bus.in_hash  = 16'(h);
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run(input string tag, input int h[8], input int ix[8], input int n);
        for (int i = 0; i < n; i++) begin
            send(ix[i], h[i], i == n - 1);
            if (i == n - 2) chk({tag, "_early_rv"}, 32'(bus.res_valid), 0);
        end
        chk({tag, "_rv_lat"}, 32'(bus.res_valid), 1);
    endtask

    task automatic result(input string tag, input int mh, input int mi, input int el, input int es);
        chk({tag, "_hash"}, 32'(bus.min_hash), mh);
        chk({tag, "_idx"}, 32'(bus.min_index), mi);
        chk({tag, "_elen"}, 32'(bus.err_len), el);
        chk({tag, "_eseq"}, 32'(bus.err_seq), es);
    endtask

    task automatic release_res(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_rv_drop"}, 32'(bus.res_valid), 0);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_index = '0;
        bus.in_hash = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
        tick(); tick();
        chk("rst_rv", 32'(bus.res_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        result("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        pulse_start();
        chk("scan_busy", 32'(bus.busy), 1);
        run("basic", '{50, 40, 60, 40, 90, 70, 80, 45}, '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
        result("basic", 40, 1, 0, 0);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_hash = '0; bus.in_index = 3'd5; bus.in_last = 1'b1;
        repeat (5) tick();
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("hold_rv", 32'(bus.res_valid), 1);
        chk("hold_busy", 32'(bus.busy), 1);
        result("hold", 40, 1, 0, 0);
        release_res("basic");

        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_hash = 16'd3; bus.in_index = '0;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("idle_start_rv", 32'(bus.res_valid), 0);
        chk("idle_start_busy", 32'(bus.busy), 1);
        run("ones", '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535}, '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
        result("ones", 65535, 0, 0, 0);
        release_res("ones");

        pulse_start();
        send(0, 20, 1'b0); send(1, 30, 1'b0); send(2, 1, 1'b0);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_hash = 16'd0; bus.in_index = 3'd3;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0;
        run("restart", '{9, 10, 11, 12, 13, 14, 15, 16}, '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
        result("restart", 9, 0, 0, 0);
        release_res("restart");

        pulse_start();
        run("short", '{5, 4, 3, 2, 1, 0, 0, 0}, '{0, 1, 2, 3, 4, 0, 0, 0}, 5);
        result("short", 1, 4, 1, 0);
        release_res("short");

        pulse_start();
        run("seq", '{50, 50, 50, 10, 60, 70, 80, 90}, '{0, 1, 3, 4, 5, 6, 7, 0}, 8);
        result("seq", 10, 4, 0, 1);
        release_res("seq");

        pulse_start();
        send(0, 7, 1'b0); send(1, 6, 1'b0); send(2, 5, 1'b0);
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_index = 3'd3; bus.in_hash = 16'd1; bus.in_last = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        chk("midrst_rv", 32'(bus.res_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        result("midrst", 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_quiet", 32'(bus.res_valid), 0);
        pulse_start();
        run("after_rst", '{16, 15, 14, 13, 12, 11, 10, 9}, '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
        result("after_rst", 9, 7, 0, 0);
        release_res("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
